// File: rtl/gba_regbus_pkg.sv
// Shared types and constants for the GBA I/O register bus initiator
// and its lane-steering helper.
package gba_regbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [1:0] ACC_BYTE = 2'd0;
    localparam logic [1:0] ACC_HALF = 2'd1;
    localparam logic [1:0] ACC_WORD = 2'd2;

    localparam int DEF_READ_LAT = 1;
    localparam int DEF_TIMEOUT  = 15;

    // Size code 3 has no encoding of its own and behaves as a word access.
    function automatic logic [1:0] acc_norm(input logic [1:0] size);
        return (size == 2'd3) ? ACC_WORD : size;
    endfunction

endpackage

// File: rtl/gba_regbus_master_lane.sv
// Combinational lane steering for the GBA register bus: byte enables and
// replicated write data from (addr, size, wdata), and right-aligned,
// zero-extended read data from (addr, size, dout). Also used by the DMA path.
module gba_regbus_lane
    import gba_regbus_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] dout,
    output logic [3:0]  be,
    output logic [31:0] din,
    output logic [31:0] rdata
);

    logic [1:0]  acc;
    logic [4:0]  shift;
    logic [31:0] shifted;

    assign acc = acc_norm(size);

    // Byte enables, write-lane replication and read shift amount per access size.
    always_comb begin
        be    = 4'hF;
        din   = wdata;
        shift = '0;
        case (acc)
            ACC_BYTE: begin
                be    = 4'b0001 << addr;
                din   = {4{wdata[7:0]}};
                shift = {addr, 3'b000};
            end
            ACC_HALF: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                din   = {2{wdata[15:0]}};
                shift = {addr[1], 4'b0000};
            end
            default: begin
                be    = 4'hF;
                din   = wdata;
                shift = '0;
            end
        endcase
    end

    // Right-align the addressed lanes and zero-extend to the access width.
    always_comb begin
        shifted = dout >> shift;
        case (acc)
            ACC_BYTE: rdata = {24'h0, shifted[7:0]};
            ACC_HALF: rdata = {16'h0, shifted[15:0]};
            default:  rdata = shifted;
        endcase
    end

endmodule

// File: rtl/gba_regbus_master.sv
// GBA I/O register bus initiator: one CPU access at a time, converted into a
// word-aligned bus cycle with a single-cycle gb_bus_ena strobe.
// Optional feature macro: GBA_REGBUS_DONE_WAIT_EN (wait for gb_bus_done with
// a TIMEOUT bound instead of the fixed READ_LAT read latency).
module gba_regbus_master
    import gba_regbus_pkg::*;
#(
    parameter int READ_LAT = DEF_READ_LAT,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [27:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] gb_bus_din,
    input  logic [31:0] gb_bus_dout,
    output logic [27:0] gb_bus_adr,
    output logic        gb_bus_rnw,
    output logic        gb_bus_ena,
    output logic [3:0]  gb_bus_be,
    output logic [1:0]  gb_bus_acc,
    input  logic        gb_bus_done,
    output logic        gb_bus_rst
);

    localparam int CNT_MAX = ((READ_LAT > TIMEOUT) ? READ_LAT : TIMEOUT) + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef GBA_REGBUS_DONE_WAIT_EN
    localparam logic [CNT_W-1:0] TO_CMP  = CNT_W'(TIMEOUT);
`else
    localparam logic [CNT_W-1:0] LAT_CMP = CNT_W'(READ_LAT);
    logic unused_done;
    assign unused_done = gb_bus_done;
`endif

    state_t           state;
    logic [1:0]       addr_lo_q;
    logic [1:0]       size_q;
    logic             write_q;
    logic [CNT_W-1:0] wait_cnt;

    logic [1:0]       lane_addr;
    logic [1:0]       lane_size;
    logic [3:0]       lane_be;
    logic [31:0]      lane_din;
    logic [31:0]      lane_rdata;

    // One steering instance serves both directions: in IDLE it shapes the
    // incoming request, afterwards it extracts read data for the latched access.
    assign lane_addr = (state == ST_IDLE) ? req_addr[1:0] : addr_lo_q;
    assign lane_size = (state == ST_IDLE) ? req_size      : size_q;

    gba_regbus_lane u_lane (
        .addr  (lane_addr),
        .size  (lane_size),
        .wdata (req_wdata),
        .dout  (gb_bus_dout),
        .be    (lane_be),
        .din   (lane_din),
        .rdata (lane_rdata)
    );

    // Bus reset to the responders follows the system reset by one cycle.
    always_ff @(posedge clk) begin
        gb_bus_rst <= reset;
    end

    // Access sequencer: IDLE -> ISSUE -> (WAIT) -> RESP, all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            gb_bus_ena <= 1'b0;
            gb_bus_adr <= '0;
            gb_bus_din <= '0;
            gb_bus_be  <= '0;
            gb_bus_rnw <= 1'b1;
            gb_bus_acc <= '0;
            addr_lo_q  <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            gb_bus_ena <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_lo_q  <= req_addr[1:0];
                        size_q     <= req_size;
                        write_q    <= req_write;
                        gb_bus_adr <= {req_addr[27:2], 2'b00};
                        gb_bus_din <= lane_din;
                        gb_bus_be  <= lane_be;
                        gb_bus_rnw <= ~req_write;
                        gb_bus_acc <= req_size;
                        gb_bus_ena <= 1'b1;
                        req_ready  <= 1'b0;
                        state      <= ST_ISSUE;
                    end else begin
                        req_ready  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= CNT_W'(1);
`ifdef GBA_REGBUS_DONE_WAIT_EN
                    state    <= ST_WAIT;
`else
                    if (write_q) begin
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else if (READ_LAT == 0) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= lane_rdata;
                        state      <= ST_RESP;
                    end else begin
                        state      <= ST_WAIT;
                    end
`endif
                end
                ST_WAIT: begin
`ifdef GBA_REGBUS_DONE_WAIT_EN
                    if (gb_bus_done) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        if (!write_q) begin
                            resp_rdata <= lane_rdata;
                        end
                        state      <= ST_RESP;
                    end else if (wait_cnt >= TO_CMP) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        state      <= ST_RESP;
                    end else begin
                        wait_cnt   <= wait_cnt + CNT_W'(1);
                    end
`else
                    if (wait_cnt >= LAT_CMP) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= lane_rdata;
                        state      <= ST_RESP;
                    end else begin
                        wait_cnt   <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gba_regbus_master.sv
// Directed self-checking bench for gba_regbus_master.
// Default build checks fixed-latency behaviour; with GBA_REGBUS_DONE_WAIT_EN
// defined it checks the done-wait and timeout paths instead.
module tb_gba_regbus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [27:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] gb_bus_din;
    logic [31:0] gb_bus_dout;
    logic [27:0] gb_bus_adr;
    logic        gb_bus_rnw;
    logic        gb_bus_ena;
    logic [3:0]  gb_bus_be;
    logic [1:0]  gb_bus_acc;
    logic        gb_bus_done;
    logic        gb_bus_rst;

    int checks   = 0;
    int failures = 0;

    gba_regbus_master #(
        .READ_LAT (1),
        .TIMEOUT  (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .gb_bus_din  (gb_bus_din),
        .gb_bus_dout (gb_bus_dout),
        .gb_bus_adr  (gb_bus_adr),
        .gb_bus_rnw  (gb_bus_rnw),
        .gb_bus_ena  (gb_bus_ena),
        .gb_bus_be   (gb_bus_be),
        .gb_bus_acc  (gb_bus_acc),
        .gb_bus_done (gb_bus_done),
        .gb_bus_rst  (gb_bus_rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (req_ready !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic drive_req(input logic wr, input logic [27:0] addr,
                             input logic [1:0] size, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
    endtask

    // Clobber request fields after acceptance so the DUT must use its latched copy.
    task automatic scramble_req();
        req_valid = 1'b0;
        req_addr  = 28'hFFFFFFF;
        req_size  = 2'd0;
        req_wdata = 32'hFFFFFFFF;
    endtask

    typedef struct {
        string       tag;
        logic        wr;
        logic [27:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] dout;
        logic [27:0] exp_adr;
        logic [3:0]  exp_be;
        logic [31:0] exp_din;
        logic [31:0] exp_rdata;
    } vec_t;

    // One full fixed-latency access with timing and field checks.
    task automatic do_access(input vec_t v);
        wait_ready(v.tag);
        drive_req(v.wr, v.addr, v.size, v.wdata);
        @(negedge clk);                                   // T+1
        scramble_req();
        check({v.tag, "_ena"},  {31'b0, gb_bus_ena}, 32'd1);
        check({v.tag, "_adr"},  {4'b0, gb_bus_adr}, {4'b0, v.exp_adr});
        check({v.tag, "_be"},   {28'b0, gb_bus_be}, {28'b0, v.exp_be});
        check({v.tag, "_rnw"},  {31'b0, gb_bus_rnw}, {31'b0, ~v.wr});
        check({v.tag, "_acc"},  {30'b0, gb_bus_acc}, {30'b0, v.size});
        check({v.tag, "_busy"}, {31'b0, req_ready}, 32'd0);
        if (v.wr) check({v.tag, "_din"}, gb_bus_din, v.exp_din);
        gb_bus_dout = 32'hA5A50F0F;
        @(negedge clk);                                   // T+2
        check({v.tag, "_ena_off"}, {31'b0, gb_bus_ena}, 32'd0);
        if (v.wr) begin
            check({v.tag, "_wresp"}, {31'b0, resp_valid}, 32'd1);
            check({v.tag, "_be_hold"}, {28'b0, gb_bus_be}, {28'b0, v.exp_be});
        end else begin
            check({v.tag, "_early"}, {31'b0, resp_valid}, 32'd0);
            gb_bus_dout = v.dout;
            @(negedge clk);                               // T+3
            gb_bus_dout = 32'h5A5AF0F0;
            check({v.tag, "_rresp"}, {31'b0, resp_valid}, 32'd1);
            check({v.tag, "_rdata"}, resp_rdata, v.exp_rdata);
            check({v.tag, "_err"},   {31'b0, resp_err}, 32'd0);
        end
        check({v.tag, "_adr_hold"}, {4'b0, gb_bus_adr}, {4'b0, v.exp_adr});
        @(negedge clk);
        check({v.tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
        check({v.tag, "_idle"},  {31'b0, req_ready}, 32'd1);
        if (!v.wr) check({v.tag, "_rdata_hold"}, resp_rdata, v.exp_rdata);
    endtask

    vec_t vecs[$];

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_size    = '0;
        req_wdata   = '0;
        gb_bus_dout = '0;
        gb_bus_done = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_rvalid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'b0, resp_err}, 32'd0);
        check("rst_ena", {31'b0, gb_bus_ena}, 32'd0);
        check("rst_adr", {4'b0, gb_bus_adr}, 32'd0);
        check("rst_din", gb_bus_din, 32'd0);
        check("rst_be", {28'b0, gb_bus_be}, 32'd0);
        check("rst_rnw", {31'b0, gb_bus_rnw}, 32'd1);
        check("rst_acc", {30'b0, gb_bus_acc}, 32'd0);
        check("rst_busrst", {31'b0, gb_bus_rst}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("busrst_release", {31'b0, gb_bus_rst}, 32'd0);

`ifndef GBA_REGBUS_DONE_WAIT_EN
        vecs.push_back('{"rd_word_100",  1'b0, 28'h0000100, 2'd2, 32'h0,        32'h00C31234, 28'h0000100, 4'hF, 32'h0,        32'h00C31234});
        vecs.push_back('{"wr_byte_103",  1'b1, 28'h0000103, 2'd0, 32'h0000005A, 32'h0,        28'h0000100, 4'h8, 32'h5A5A5A5A, 32'h0});
        vecs.push_back('{"rd_half_102",  1'b0, 28'h0000102, 2'd1, 32'h0,        32'hBEEFCAFE, 28'h0000100, 4'hC, 32'h0,        32'h0000BEEF});
        vecs.push_back('{"rd_half_103",  1'b0, 28'h0000103, 2'd1, 32'h0,        32'hBEEFCAFE, 28'h0000100, 4'hC, 32'h0,        32'h0000BEEF});
        vecs.push_back('{"rd_byte_201",  1'b0, 28'h0000201, 2'd0, 32'h0,        32'h11223344, 28'h0000200, 4'h2, 32'h0,        32'h00000033});
        vecs.push_back('{"wr_half_040",  1'b1, 28'h0000040, 2'd1, 32'hABCD1234, 32'h0,        28'h0000040, 4'h3, 32'h12341234, 32'h0});
        vecs.push_back('{"wr_word_106",  1'b1, 28'h0000106, 2'd2, 32'hCAFEF00D, 32'h0,        28'h0000104, 4'hF, 32'hCAFEF00D, 32'h0});
        vecs.push_back('{"rd_size3_203", 1'b0, 28'h0000203, 2'd3, 32'h0,        32'h87654321, 28'h0000200, 4'hF, 32'h0,        32'h87654321});
        vecs.push_back('{"rd_half_100",  1'b0, 28'h0000100, 2'd1, 32'h0,        32'hBEEFCAFE, 28'h0000100, 4'h3, 32'h0,        32'h0000CAFE});
        vecs.push_back('{"wr_byte_top",  1'b1, 28'hFFFFFFE, 2'd0, 32'h000000C7, 32'h0,        28'hFFFFFFC, 4'h4, 32'hC7C7C7C7, 32'h0});
        foreach (vecs[i]) do_access(vecs[i]);

        // Back-to-back writes with req_valid held high.
        begin
            int   accepts  = 0;
            int   enas     = 0;
            int   resps    = 0;
            int   dbl      = 0;
            int   gap_bad  = 0;
            int   last_ena = 0;
            logic prev_ena = 1'b0;
            wait_ready("b2b");
            drive_req(1'b1, 28'h0000010, 2'd2, 32'h01020304);
            for (int c = 0; c < 20; c++) begin
                if (accepts == 4) req_valid = 1'b0;
                if (req_valid && req_ready) accepts++;
                @(negedge clk);
                if (gb_bus_ena) begin
                    enas++;
                    if (prev_ena) dbl++;
                    if (enas > 1 && (c - last_ena) != 3) gap_bad++;
                    last_ena = c;
                end
                prev_ena = gb_bus_ena;
                if (resp_valid) resps++;
            end
            check("b2b_accepts", accepts, 32'd4);
            check("b2b_ena_pulses", enas, 32'd4);
            check("b2b_ena_width", dbl, 32'd0);
            check("b2b_ena_spacing", gap_bad, 32'd0);
            check("b2b_resps", resps, 32'd4);
        end

        // Reset asserted in the WAIT cycle of a read aborts it.
        wait_ready("abort");
        drive_req(1'b0, 28'h0000300, 2'd2, 32'h0);
        @(negedge clk);                                   // ISSUE
        scramble_req();
        check("abort_ena", {31'b0, gb_bus_ena}, 32'd1);
        @(negedge clk);                                   // WAIT
        gb_bus_dout = 32'h11111111;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_rst_rvalid", {31'b0, resp_valid}, 32'd0);
            check("abort_rst_ena", {31'b0, gb_bus_ena}, 32'd0);
            check("abort_rst_ready", {31'b0, req_ready}, 32'd0);
        end
        check("abort_rst_rnw", {31'b0, gb_bus_rnw}, 32'd1);
        check("abort_rst_adr", {4'b0, gb_bus_adr}, 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_post_rvalid", {31'b0, resp_valid}, 32'd0);
            check("abort_post_ena", {31'b0, gb_bus_ena}, 32'd0);
        end
        check("abort_rdata_clr", resp_rdata, 32'd0);
        do_access('{"post_abort_rd", 1'b0, 28'h0000304, 2'd2, 32'h0, 32'h0BADF00D, 28'h0000304, 4'hF, 32'h0, 32'h0BADF00D});
`else
        // done arrives in the third WAIT cycle.
        wait_ready("dw");
        drive_req(1'b0, 28'h0000100, 2'd2, 32'h0);
        @(negedge clk);                                   // T+1 ISSUE
        scramble_req();
        check("dw_ena", {31'b0, gb_bus_ena}, 32'd1);
        gb_bus_dout = 32'hA5A50F0F;
        @(negedge clk);                                   // T+2 WAIT1
        check("dw_wait1", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);                                   // T+3 WAIT2
        check("dw_wait2", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);                                   // T+4 WAIT3
        check("dw_wait3", {31'b0, resp_valid}, 32'd0);
        gb_bus_done = 1'b1;
        gb_bus_dout = 32'h13579BDF;
        @(negedge clk);                                   // T+5 RESP
        gb_bus_done = 1'b0;
        gb_bus_dout = 32'hA5A50F0F;
        check("dw_resp", {31'b0, resp_valid}, 32'd1);
        check("dw_rdata", resp_rdata, 32'h13579BDF);
        check("dw_err", {31'b0, resp_err}, 32'd0);
        @(negedge clk);
        check("dw_pulse", {31'b0, resp_valid}, 32'd0);

        // done only in the ISSUE cycle is ignored; the access times out.
        wait_ready("to");
        drive_req(1'b0, 28'h0000102, 2'd1, 32'h0);
        @(negedge clk);                                   // T+1 ISSUE
        scramble_req();
        gb_bus_done = 1'b1;
        for (int i = 2; i <= 16; i++) begin
            @(negedge clk);                               // WAIT cycles
            gb_bus_done = 1'b0;
            check("to_waiting", {31'b0, resp_valid}, 32'd0);
        end
        @(negedge clk);                                   // T+17
        check("to_resp", {31'b0, resp_valid}, 32'd1);
        check("to_err", {31'b0, resp_err}, 32'd1);
        check("to_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        check("to_pulse", {31'b0, resp_valid}, 32'd0);
        check("to_idle", {31'b0, req_ready}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gba_regbus_master.md
# gba_regbus_master

Initiator for the GBA I/O register bus (`gb_bus_*`). It accepts one CPU-side I/O access at a time, of byte, halfword or word size, and converts it to a word-aligned bus cycle with byte enables. It issues a single-cycle `gb_bus_ena` strobe, collects read data from the responders (timers, DMA, PPU registers) and returns lane-steered data to the CPU. It sits between the CPU memory-access unit and all `eProcReg_gba` register responders.

## Interface
- `READ_LAT`, 1: cycles from the `gb_bus_ena` cycle until `gb_bus_dout` is valid (responders register their read data).
- `TIMEOUT`, 15: maximum wait cycles for `gb_bus_done`; only used with `GBA_REGBUS_DONE_WAIT_EN`.
- `clk` in 1: 16.7 MHz system clock.
- `reset` in 1: synchronous, active-high; clock `clk`.
- `req_valid` in 1: CPU access request.
- `req_ready` out 1: high only in IDLE.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 28: byte address.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `req_wdata` in 32: write data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: read data, right-aligned and zero-extended.
- `resp_err` out 1: timeout flag, qualified by `resp_valid`.
- `gb_bus_din` out 32: lane-replicated write data.
- `gb_bus_dout` in 32: responder read data.
- `gb_bus_adr` out 28: word address (`req_addr & ~3`).
- `gb_bus_rnw` out 1: 1 = read.
- `gb_bus_ena` out 1: one-cycle strobe.
- `gb_bus_be` out 4: byte enables.
- `gb_bus_acc` out 2: copy of the size field.
- `gb_bus_done` in 1: responder completion.
- `gb_bus_rst` out 1: bus reset to the responders.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: `req_valid` latches all request fields and moves to ISSUE.
  - ISSUE drives `gb_bus_ena`=1 for exactly one cycle. A write then goes to RESP; a read goes to WAIT.
  - WAIT counts `READ_LAT` cycles, samples `gb_bus_dout`, then goes to RESP.
  - RESP pulses `resp_valid` and returns to IDLE.
- Byte enables:
  - byte: `be = 1 << addr[1:0]`.
  - half: `be = addr[1] ? 4'b1100 : 4'b0011`; `addr[0]` is ignored (forced alignment).
  - word: `be = 4'hF`; `addr[1:0]` is ignored.
- Write data: byte is replicated ×4, half is replicated ×2, word is passed unchanged.
- Read data: the shift is `dout >> (8*addr[1:0])`. For halfwords the shift uses `addr[1]` only. The result is masked to 8/16/32 bits and zero-extended.
- `gb_bus_adr`, `gb_bus_din`, `gb_bus_be`, `gb_bus_rnw` and `gb_bus_acc` hold their values from ISSUE through RESP. In IDLE they keep their last values; only `gb_bus_ena` carries meaning.
- `gb_bus_rst` is `reset` registered once (one-cycle delay).
- Reset values:
  - `req_ready`=0 while reset is asserted, then 1.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - `gb_bus_ena`=0, `gb_bus_adr`=0, `gb_bus_din`=0, `gb_bus_be`=0, `gb_bus_rnw`=1, `gb_bus_acc`=0.
- Reset during an access aborts it. FSM goes to IDLE, no `resp_valid` is produced, and `gb_bus_ena` is never asserted after reset.
- A `req_valid` presented while not in IDLE is ignored (`req_ready`=0). The CPU must hold the request.

## Timing
- Request accepted at cycle T (`req_valid & req_ready`).
- `gb_bus_ena` is high in cycle T+1.
- Write: `resp_valid` in T+2. Minimum write throughput is one access per 3 cycles.
- Read: `gb_bus_dout` is sampled at the end of cycle T+1+`READ_LAT`; `resp_valid` is high in T+2+`READ_LAT` (T+3 at the default).
- `resp_rdata` stays stable until the next `resp_valid`.

## Configuration
- `GBA_REGBUS_DONE_WAIT_EN` defined:
  - WAIT exits on `gb_bus_done`=1, sampling `dout` in that same cycle, or after `TIMEOUT` cycles.
  - On timeout: `resp_err`=1 and `resp_rdata`=0.
  - A `done` arriving in the ISSUE cycle is ignored.
  - Writes also wait for `done`.
- Undefined: fixed `READ_LAT` behaviour; `gb_bus_done` is ignored; `resp_err` is tied to 0.

## Structure
- Package `gba_regbus_pkg` holds:
  - the FSM state enum;
  - the `ACC_BYTE`/`ACC_HALF`/`ACC_WORD` constants;
  - the default `READ_LAT`/`TIMEOUT`.
- Sub-module `gba_regbus_lane`: combinational lane steering. It produces `be` and replicated `din` from (addr, size, wdata), and extracted `rdata` from (addr, size, dout). It is shared with the DMA bus path.

## Test plan
- Word read at 0x100, responder returns 0x00C3_1234 one cycle after `ena` -> `be`=F, `adr`=0x100, `resp_rdata`=0x00C31234 at T+3.
- Byte write 0x5A at 0x103 -> `be`=4'b1000, `din`=0x5A5A5A5A, `rnw`=0, `resp_valid` at T+2.
- Half read at 0x102 (and at misaligned 0x103), `dout`=0xBEEF_CAFE -> `rdata`=0x0000BEEF in both cases, `be`=4'b1100.
- `req_valid` held high for 4 back-to-back accesses -> exactly 4 `ena` pulses, each 1 cycle, `req_ready` low between accepts.
- Reset asserted in the WAIT cycle of a read -> no `resp_valid`; next request completes normally.
- With `GBA_REGBUS_DONE_WAIT_EN`: `done` after 3 cycles -> normal response. `done` never asserted -> `resp_err`=1 and `rdata`=0 after 15 wait cycles.
